// File: rtl/prefix_adder_32.sv
// Registered 32-bit adder with carry-in/out on a Kogge-Stone carry network, one cycle of latency.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output Ovf.
module prefix_adder_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic        out_valid,
    output logic [31:0] Sum,
    output logic        Cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic        Ovf
`endif
);

    localparam int WIDTH = 32;

    // in_valid qualifies A/B/Cin at a rising edge; out_valid marks Sum/Cout as
    // holding the result captured at the previous edge. There is no ready: the
    // adder accepts one operand set every cycle.

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;

    // Level 0 group terms; Cin is folded into bit 0 so G[i] becomes the carry into bit i+1.
    logic [WIDTH-1:0] g_l0;
    logic [WIDTH-1:0] g_l1;
    logic [WIDTH-1:0] g_l2;
    logic [WIDTH-1:0] g_l3;
    logic [WIDTH-1:0] g_l4;
    logic [WIDTH-1:0] g_l5;
    logic [WIDTH-1:2]  p_l1;
    logic [WIDTH-1:4]  p_l2;
    logic [WIDTH-1:8]  p_l3;
    logic [WIDTH-1:16] p_l4;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    assign g_bit = A & B;
    assign p_bit = A ^ B;

    assign g_l0 = {g_bit[WIDTH-1:1], g_bit[0] | (p_bit[0] & Cin)};

    genvar i;

    // Group propagate is only kept where a later level still consumes it; cells
    // whose span already reaches bit 0 are gray and produce G alone.
    for (i = 0; i < WIDTH; i++) begin : g_lvl1
        if (i < 1) begin : g_pass
            assign g_l1[i] = g_l0[i];
        end else begin : g_cell
            assign g_l1[i] = g_l0[i] | (p_bit[i] & g_l0[i-1]);
        end
        if (i >= 2) begin : g_black
            assign p_l1[i] = p_bit[i] & p_bit[i-1];
        end
    end

    for (i = 0; i < WIDTH; i++) begin : g_lvl2
        if (i < 2) begin : g_pass
            assign g_l2[i] = g_l1[i];
        end else begin : g_cell
            assign g_l2[i] = g_l1[i] | (p_l1[i] & g_l1[i-2]);
        end
        if (i >= 4) begin : g_black
            assign p_l2[i] = p_l1[i] & p_l1[i-2];
        end
    end

    for (i = 0; i < WIDTH; i++) begin : g_lvl3
        if (i < 4) begin : g_pass
            assign g_l3[i] = g_l2[i];
        end else begin : g_cell
            assign g_l3[i] = g_l2[i] | (p_l2[i] & g_l2[i-4]);
        end
        if (i >= 8) begin : g_black
            assign p_l3[i] = p_l2[i] & p_l2[i-4];
        end
    end

    for (i = 0; i < WIDTH; i++) begin : g_lvl4
        if (i < 8) begin : g_pass
            assign g_l4[i] = g_l3[i];
        end else begin : g_cell
            assign g_l4[i] = g_l3[i] | (p_l3[i] & g_l3[i-8]);
        end
        if (i >= 16) begin : g_black
            assign p_l4[i] = p_l3[i] & p_l3[i-8];
        end
    end

    for (i = 0; i < WIDTH; i++) begin : g_lvl5
        if (i < 16) begin : g_pass
            assign g_l5[i] = g_l4[i];
        end else begin : g_cell
            assign g_l5[i] = g_l4[i] | (p_l4[i] & g_l4[i-16]);
        end
    end

    assign carry  = {g_l5, Cin};
    assign sum_d  = p_bit ^ carry[WIDTH-1:0];
    assign cout_d = carry[WIDTH];

`ifdef OVERFLOW_FLAG_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

    // Results only load on a valid edge, so X operands while idle never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_prefix_adder_32.sv
// Directed and random checks of prefix_adder_32; Ovf is checked when OVERFLOW_FLAG_EN is defined.
module tb_prefix_adder_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        out_valid;
    logic [31:0] Sum;
    logic        Cout;
`ifdef OVERFLOW_FLAG_EN
    logic        Ovf;
`endif

    int n_vec;
    int n_err;

    // {ovf, cout, sum} per accepted operand set
    logic [33:0] exp_q[$];
    logic [33:0] last_res;
    logic        mon_v;

    prefix_adder_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .Sum       (Sum),
`ifdef OVERFLOW_FLAG_EN
        .Ovf       (Ovf),
`endif
        .Cout      (Cout)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [32:0] exp, input logic ovf);
        @(negedge clk);
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        exp_q.push_back({ovf, exp});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A        = 'x;
            B        = 'x;
            Cin      = 1'bx;
        end
    endtask

    task automatic send_rand();
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] s;
        a   = $urandom();
        b   = $urandom();
        cin = 1'($urandom_range(0, 1));
        s   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        send(a, b, cin, s, (a[31] == b[31]) && (s[31] != a[31]));
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        mon_v = in_valid;
        #1;
        if (!rst) begin
            check("out_valid", {32'd0, out_valid}, {32'd0, mon_v});
            if (mon_v) begin
                check("sb_underrun", {32'd0, exp_q.size() == 0}, 33'd0);
                if (exp_q.size() > 0) last_res = exp_q.pop_front();
            end
            check(mon_v ? "sum_cout" : "hold", {Cout, Sum}, last_res[32:0]);
`ifdef OVERFLOW_FLAG_EN
            check("ovf", {32'd0, Ovf}, {32'd0, last_res[33]});
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        last_res = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;

        // Outputs must be clear before any clock edge has occurred.
        #2;
        check("rst_sum", {Cout, Sum}, 33'd0);
        check("rst_valid", {32'd0, out_valid}, 33'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        send(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0001, 1'b0);
        send(32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, 1'b0);
        idle(3);

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1);
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001, 1'b0);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000, 1'b0);
        idle(1);

        // Reset lands mid-cycle with an operand set already presented.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 33'h0_3333_3333, 1'b0);
        send(32'h4444_4444, 32'h4444_4444, 1'b1, 33'h0_8888_8889, 1'b1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        last_res = '0;
        #1;
        check("mid_rst_sum", {Cout, Sum}, 33'd0);
        check("mid_rst_valid", {32'd0, out_valid}, 33'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 33'h1_0000_0000, 1'b0);
        idle(1);

        for (int n = 0; n < 1000; n++) begin
            send_rand();
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(2);
        check("drain", {32'd0, exp_q.size() == 0}, 33'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
